memory_arbiter: RTL and testbench

- Sequences the single-port data memory and shares it between two requesters: instruction fetch (IF) and the load/store/stack data path (D).
- Each requester uses a level-request / pulse-acknowledge handshake.
- The arbiter registers the winning address, write data and write enable, and drives the memory port.
- It then waits out the memory read latency and returns read data to the winning requester.
- It sits between the control unit's fetch/memory stages and the `memory` instance.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_fairness.sv | 42 ++++
 rtl/memory_arbiter.sv | 153 +++++++++++++++
 tb/tb_memory_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter.
// Holds the arbiter state encoding, the grant encoding and the bus widths
// used by memory_arbiter and mem_arb_fairness.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_fairness.sv
// Winner selection and data-burst limiter for the memory arbiter.
// The data path normally wins a collision. After DATA_BURST_MAX consecutive
// data grants made while fetch was waiting, fetch wins the next collision.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   if_req, d_req   current request levels
//   grant_strobe    high in the cycle a grant is taken (IDLE with a request)
//   winner          requester that wins if a grant is taken this cycle
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int DATA_BURST_MAX = 2
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   grant_strobe,
  output grant_t winner
);

  logic [3:0] burst_cnt;

  always_comb begin
    winner = GNT_IF;
    if (d_req && !(if_req && (burst_cnt == 4'(DATA_BURST_MAX))))
      winner = GNT_D;
  end

  // Only data grants taken while fetch waits extend the burst.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      burst_cnt <= 4'd0;
    else if (grant_strobe) begin
      if ((winner == GNT_D) && if_req)
        burst_cnt <= burst_cnt + 4'd1;
      else
        burst_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single-port data memory between instruction fetch (IF) and the
// load/store data path (D). Each requester holds a level request until a
// one-cycle ack. The winner's address/write data/write enable are latched in
// IDLE, driven to memory in ACCESS, reads wait RD_LAT cycles in WAIT, and
// DONE pulses the winner's ack.
// Optional build macro: MEM_ARB_ALIGN_CHECK_EN -- odd addresses are rejected
// with an err-flagged ack one cycle after the grant and never reach memory.
// Ports:
//   clock, reset_n                      clock, asynchronous active-low reset
//   if_req/if_addr/if_ack/if_rdata/if_err   fetch port
//   d_req/d_we/d_addr/d_wdata/d_ack/d_rdata/d_err   data port
//   mem_addr/mem_wdata/mem_write/mem_read/mem_rdata memory port
//   busy                                high whenever the FSM is not IDLE
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT         = 1,
  parameter int DATA_BURST_MAX = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state, state_nxt;
  grant_t            winner, gnt;
  logic [ADDR_W-1:0] addr_q, win_addr;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
  logic              we_q, win_we;
  logic [2:0]        wait_cnt;
  logic              req_any, grant_strobe, odd_addr, last_wait;

  assign req_any      = if_req | d_req;
  assign grant_strobe = (state == IDLE) && req_any;
  assign win_addr     = (winner == GNT_D) ? d_addr : if_addr;
  assign win_we       = (winner == GNT_D) && d_we;
  assign last_wait    = (wait_cnt == 3'(RD_LAT - 1));

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic err_q;

  assign odd_addr = win_addr[0];
  assign if_err   = if_ack & err_q;
  assign d_err    = d_ack & err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (grant_strobe)
      err_q <= odd_addr;
  end
`else
  assign odd_addr = 1'b0;
  assign if_err   = 1'b0;
  assign d_err    = 1'b0;
`endif

  mem_arb_fairness #(
    .DATA_BURST_MAX(DATA_BURST_MAX)
  ) u_fairness (
    .clock       (clock),
    .reset_n     (reset_n),
    .if_req      (if_req),
    .d_req       (d_req),
    .grant_strobe(grant_strobe),
    .winner      (winner)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    case (state)
      IDLE:    if (req_any) state_nxt = odd_addr ? DONE : ACCESS;
      ACCESS: begin
        mem_write = we_q;
        mem_read  = ~we_q;
        state_nxt = we_q ? DONE : WAIT;
      end
      WAIT:    if (last_wait) state_nxt = DONE;
      DONE: begin
        if_ack    = (gnt == GNT_IF);
        d_ack     = (gnt == GNT_D);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Rejected (odd) accesses leave the memory-side registers untouched so the
  // memory port keeps its previous address and data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt        <= GNT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt   <= 3'd0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_strobe) begin
        gnt  <= winner;
        we_q <= win_we;
        if (!odd_addr) begin
          addr_q <= win_addr;
          if (win_we)
            wdata_q <= d_wdata;
        end
      end
      wait_cnt <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;
      if ((state == WAIT) && last_wait) begin
        if (gnt == GNT_D)
          d_rdata_q <= mem_rdata;
        else
          if_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: a table of single transactions, then
// back-to-back, collision/burst, reset-abort and odd-address sequences.
// Expected completions are queued per port when a request is raised and
// checked by a monitor when the matching ack appears.
module tb_memory_arbiter;

  localparam int RD_LAT = 1;
  localparam int BURST  = 2;
  localparam int LAT_RD = RD_LAT + 2;
  localparam int LAT_WR = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_ack, if_err, d_ack, d_err;
  logic [15:0] if_rdata, d_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, busy;

  always #5 clock = ~clock;

  memory_arbiter #(.RD_LAT(RD_LAT), .DATA_BURST_MAX(BURST)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: 256 words indexed by the low address byte, fixed RD_LAT.
  function automatic logic [15:0] init_word(input logic [7:0] a);
    case (a)
      8'h00:   return 16'hFFFF;
      8'h03:   return 16'h3333;
      8'h04:   return 16'h1234;
      8'h10:   return 16'h0101;
      8'h20:   return 16'hAAAA;
      8'hFE:   return 16'hCAFE;
      default: return {8'hA5, a};
    endcase
  endfunction

  logic        mem_init;
  logic [15:0] mem_m [0:255];
  logic [15:0] rd_pipe [RD_LAT];
  int          cyc = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_m[i] <= init_word(8'(i));
    end else if (mem_write)
      mem_m[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= mem_read ? mem_m[mem_addr[7:0]] : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  typedef struct { bit we; bit err; logic [15:0] rdata; } exp_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct {
    bit port; bit we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] exp_rd; int lat;
  } vec_t;

  exp_t        q_if[$], q_d[$];
  wr_t         q_wr[$];
  bit          grant_log[$];
  int          checks = 0, errors = 0, rd_cnt = 0;
  logic [15:0] last_rd_addr = 16'h0, hold_if = 16'h0, hold_d = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on ack, rdata hold checks, memory write checks.
  initial begin
    exp_t        e;
    wr_t         w;
    logic [15:0] er;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        hold_if = 16'h0;
        hold_d  = 16'h0;
      end else begin
        check("ack_exclusive", {31'b0, if_ack & d_ack}, 0);
        check("strobe_exclusive", {31'b0, mem_read & mem_write}, 0);
        if (mem_read) begin
          rd_cnt++;
          last_rd_addr = mem_addr;
        end
        if (mem_write) begin
          if (q_wr.size() == 0) check("unexpected_mem_write", {31'b0, mem_write}, 0);
          else begin
            w = q_wr.pop_front();
            check("mem_write_addr", {16'b0, mem_addr}, {16'b0, w.addr});
            check("mem_write_data", {16'b0, mem_wdata}, {16'b0, w.data});
          end
        end
        if (if_ack) begin
          grant_log.push_back(1'b0);
          if (q_if.size() == 0) check("if_unexpected_ack", {31'b0, if_ack}, 0);
          else begin
            e  = q_if.pop_front();
            er = (e.we || e.err) ? hold_if : e.rdata;
            check("if_rdata", {16'b0, if_rdata}, {16'b0, er});
            check("if_err", {31'b0, if_err}, {31'b0, e.err});
            hold_if = er;
          end
        end else check("if_rdata_hold", {16'b0, if_rdata}, {16'b0, hold_if});
        if (d_ack) begin
          grant_log.push_back(1'b1);
          if (q_d.size() == 0) check("d_unexpected_ack", {31'b0, d_ack}, 0);
          else begin
            e  = q_d.pop_front();
            er = (e.we || e.err) ? hold_d : e.rdata;
            check("d_rdata", {16'b0, d_rdata}, {16'b0, er});
            check("d_err", {31'b0, d_err}, {31'b0, e.err});
            hold_d = er;
          end
        end else check("d_rdata_hold", {16'b0, d_rdata}, {16'b0, hold_d});
      end
    end
  end

  // One transaction on one port; exp_lat < 0 skips the latency check.
  task automatic txn(input bit port, input bit we, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_rd,
                     input bit err, input int exp_lat, input bit last);
    int t0;
    bit got;
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      q_d.push_back('{we, err, exp_rd});
      if (we && !err) q_wr.push_back('{addr, wdata});
    end else begin
      if_req = 1'b1; if_addr = addr;
      q_if.push_back('{1'b0, err, exp_rd});
    end
    t0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      got = port ? d_ack : if_ack;
    end
    if (!got) check(port ? "d_ack_timeout" : "if_ack_timeout", {31'b0, got}, 1);
    else if (exp_lat >= 0) check(port ? "d_latency" : "if_latency", cyc - t0, exp_lat);
    @(posedge clock); #1;
    if (last) begin
      if (port) d_req = 1'b0;
      else      if_req = 1'b0;
    end
  endtask

  vec_t vecs [9];
  bit   exp_order [6];
  int   rd_snap;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, LAT_WR};
    vecs[1] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h1234, LAT_RD};
    vecs[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, LAT_RD};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFE, 16'h0F0F, 16'h0000, LAT_WR};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0F0F, LAT_RD};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, LAT_WR};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, LAT_RD};
    vecs[7] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hAAAA, LAT_RD};
    vecs[8] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hAAAA, LAT_RD};
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset_n = 1'b0; mem_init = 1'b1;
    if_req = 1'b0; if_addr = 16'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_strobes", {25'b0, if_ack, d_ack, if_err, d_err, mem_write, mem_read, busy}, 0);
    check("reset_rdata", {if_rdata, d_rdata}, 0);
    check("reset_mem_bus", {mem_addr, mem_wdata}, 0);
    mem_init = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++)
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0, vecs[i].lat, 1'b1);

    // Back-to-back loads: the first result must hold until the second ack.
    txn(1'b1, 1'b0, 16'h0004, 16'h0, 16'h1234, 1'b0, LAT_RD, 1'b0);
    txn(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, LAT_RD, 1'b1);

    // Both ports requesting continuously.
    grant_log.delete();
    fork
      begin
        txn(1'b1, 1'b0, 16'h0004, 16'h0,    16'h1234, 1'b0, -1, 1'b0);
        txn(1'b1, 1'b0, 16'h0010, 16'h0,    16'hBEEF, 1'b0, -1, 1'b0);
        txn(1'b1, 1'b1, 16'h0020, 16'h5555, 16'h0,    1'b0, -1, 1'b0);
        txn(1'b1, 1'b0, 16'h0020, 16'h0,    16'h5555, 1'b0, -1, 1'b1);
      end
      begin
        txn(1'b0, 1'b0, 16'h0000, 16'h0, 16'h0000, 1'b0, -1, 1'b0);
        txn(1'b0, 1'b0, 16'hFFFE, 16'h0, 16'h0F0F, 1'b0, -1, 1'b1);
      end
    join
    check("burst_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("burst_grant_%0d", i), {31'b0, grant_log[i]}, {31'b0, exp_order[i]});

    // Reset asserted while a fetch sits in WAIT.
    if_req = 1'b1; if_addr = 16'h0004;
    @(posedge clock);
    @(posedge clock); #1;
    check("busy_in_wait", {30'b0, busy, mem_read}, 32'h2);
    reset_n = 1'b0;
    #1;
    check("abort_strobes", {25'b0, if_ack, d_ack, if_err, d_err, mem_write, mem_read, busy}, 0);
    check("abort_rdata", {if_rdata, d_rdata}, 0);
    check("abort_mem_bus", {mem_addr, mem_wdata}, 0);
    if_req = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    txn(1'b0, 1'b0, 16'h0004, 16'h0, 16'h1234, 1'b0, LAT_RD, 1'b1);

    // Odd addresses.
    rd_snap = rd_cnt;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    txn(1'b1, 1'b0, 16'h0003, 16'h0, 16'h0, 1'b1, 1, 1'b1);
    txn(1'b0, 1'b0, 16'hFFFF, 16'h0, 16'h0, 1'b1, 1, 1'b1);
    txn(1'b1, 1'b1, 16'h0021, 16'h9999, 16'h0, 1'b1, 1, 1'b1);
    check("odd_no_mem_read", rd_cnt, rd_snap);
`else
    txn(1'b1, 1'b0, 16'h0003, 16'h0, 16'h3333, 1'b0, LAT_RD, 1'b1);
    check("odd_addr_passthru", {16'b0, last_rd_addr}, 32'h0003);
    txn(1'b0, 1'b0, 16'hFFFF, 16'h0, 16'hA5FF, 1'b0, LAT_RD, 1'b1);
    check("top_addr_passthru", {16'b0, last_rd_addr}, 32'hFFFF);
    check("odd_read_count", rd_cnt, rd_snap + 2);
`endif

    repeat (4) @(posedge clock);
    #1;
    check("idle_busy", {31'b0, busy}, 0);
    check("if_queue_drained", q_if.size(), 0);
    check("d_queue_drained", q_d.size(), 0);
    check("wr_queue_drained", q_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
